// File: rtl/pcileech_tlp_pkg.sv
// ----------------------------------------------------------------------------
// pcileech_tlp_pkg
// Shared types for the 128-bit TLP stream blocks in the clk_pcie domain.
//   tlp_port_t   : destination sink of a TLP (completion / memory / config / other)
//   beat_t       : one stream beat (data, DW keep, user, last)
//   tlp_classify : maps the Fmt/Type byte of DW0 to a destination sink
// ----------------------------------------------------------------------------
package pcileech_tlp_pkg;

    typedef enum logic [1:0] {
        PORT_CPL   = 2'd0,
        PORT_MEM   = 2'd1,
        PORT_CFG   = 2'd2,
        PORT_OTHER = 2'd3
    } tlp_port_t;

    typedef struct packed {
        logic [127:0] tdata;
        logic [3:0]   tkeepdw;
        logic [8:0]   tuser;
        logic         tlast;
    } beat_t;

    // fmt_type is tdata[31:24] of the first beat.
    function automatic tlp_port_t tlp_classify(input logic [7:0] fmt_type);
        tlp_port_t port;
        if (fmt_type[7:1] == 7'b0000101 || fmt_type[7:1] == 7'b0100101)
            port = PORT_CPL;
        // Fmt 000/001/010/011 with Type 00000: MRd/MWr, 3DW and 4DW headers.
        else if (fmt_type[7] == 1'b0 && fmt_type[4:0] == 5'b00000)
            port = PORT_MEM;
        else if (fmt_type[7:1] == 7'b0000010 || fmt_type[7:1] == 7'b0100010)
            port = PORT_CFG;
        else
            port = PORT_OTHER;
        return port;
    endfunction

endpackage

// File: rtl/pcileech_tlps128_reg_slice.sv
// ----------------------------------------------------------------------------
// pcileech_tlps128_reg_slice
// One-deep valid/ready register for a TLP beat.
//   clk_pcie, rst : clock, synchronous active-high reset
//   load          : capture in_beat this cycle (caller only loads when space=1)
//   in_beat       : beat to capture
//   space         : slot is empty or is being drained this cycle
//   out_beat      : registered beat, stable while out_tvalid && !out_tready
//   out_tvalid    : registered beat present
//   out_tready    : sink accepts the registered beat
// ----------------------------------------------------------------------------
module pcileech_tlps128_reg_slice
    import pcileech_tlp_pkg::*;
(
    input  logic  clk_pcie,
    input  logic  rst,
    input  logic  load,
    input  beat_t in_beat,
    output logic  space,
    output beat_t out_beat,
    output logic  out_tvalid,
    input  logic  out_tready
);

    assign space = !out_tvalid || out_tready;

    always_ff @(posedge clk_pcie) begin
        if (rst)
            out_tvalid <= 1'b0;
        else if (load)
            out_tvalid <= 1'b1;
        else if (out_tready)
            out_tvalid <= 1'b0;
    end

    // Payload needs no reset; it is only observed while out_tvalid is set.
    always_ff @(posedge clk_pcie) begin
        if (load)
            out_beat <= in_beat;
    end

endmodule

// File: rtl/pcileech_tlps128_route_demux.sv
// ----------------------------------------------------------------------------
// pcileech_tlps128_route_demux
// Packet-level 1-to-4 demux for 128-bit TLP streams. The first beat of each
// TLP is classified by Fmt/Type and the whole packet follows it to one sink:
// port 0 completions, 1 memory requests, 2 config requests, 3 everything else.
// Each port has a one-deep register slice; a full, stalled sink backpressures
// the input. Ports flagged in DROP_MASK accept and discard their packets.
//   clk_pcie, rst          : clock, synchronous active-high reset
//   in_t*                  : input stream (tuser[0] marks the first beat)
//   out_t*                 : four output streams, port n in slice [n*W +: W]
//   pkt_cnt                : per-port packets accepted (wrapping), port n in [n*CNT_W +: CNT_W]
//   err_cnt                : framing errors (saturating)
// ----------------------------------------------------------------------------
module pcileech_tlps128_route_demux
    import pcileech_tlp_pkg::*;
#(
    parameter logic [3:0] DROP_MASK = 4'b0000,
    parameter int         CNT_W     = 16
) (
    input  logic               clk_pcie,
    input  logic               rst,
    input  logic [127:0]       in_tdata,
    input  logic [3:0]         in_tkeepdw,
    input  logic [8:0]         in_tuser,
    input  logic               in_tlast,
    input  logic               in_tvalid,
    output logic               in_tready,
    output logic [511:0]       out_tdata,
    output logic [15:0]        out_tkeepdw,
    output logic [35:0]        out_tuser,
    output logic [3:0]         out_tlast,
    output logic [3:0]         out_tvalid,
    input  logic [3:0]         out_tready,
    output logic [4*CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0]   err_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PKT  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state, state_nxt;
    tlp_port_t        sel, sel_nxt;
    tlp_port_t        cls, tgt;
    logic [1:0]       tgt_idx;
    logic             first, in_pkt, fire, tgt_rdy;
    logic             err_evt, cnt_evt;
    logic [3:0]       load, space;
    beat_t            in_beat;
    beat_t            out_beat [4];
    logic [CNT_W-1:0] cnt [4];

    assign first   = in_tuser[0];
    assign cls     = tlp_classify(in_tdata[31:24]);
    assign in_beat = '{tdata: in_tdata, tkeepdw: in_tkeepdw, tuser: in_tuser, tlast: in_tlast};

    // A first beat always goes to its own classification, even mid-packet
    // (the restart case), so readiness is judged on that port rather than sel.
    always_comb begin
        tgt       = first ? cls : sel;
        tgt_idx   = tgt;
        tgt_rdy   = DROP_MASK[tgt_idx] || space[tgt_idx];
        in_pkt    = first || (state == S_PKT);
        in_tready = 1'b0;
        if (!rst) begin
            if (state == S_IDLE && !first)
                in_tready = 1'b1;   // orphan beat, swallowed
            else
                in_tready = tgt_rdy;
        end
        fire      = in_tvalid && in_tready;
        err_evt   = fire && (in_pkt ? (state == S_PKT && first) : 1'b1);
        cnt_evt   = fire && in_pkt && in_tlast;
        for (int i = 0; i < 4; i++)
            load[i] = fire && in_pkt && (tgt_idx == 2'(i)) && !DROP_MASK[i];
    end

    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            state <= S_IDLE;
            sel   <= PORT_CPL;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        if (fire && in_pkt) begin
            sel_nxt   = tgt;
            state_nxt = in_tlast ? S_IDLE : S_PKT;
        end
    end

    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                cnt[i] <= '0;
            err_cnt <= '0;
        end else begin
            if (cnt_evt)
                cnt[tgt_idx] <= cnt[tgt_idx] + CNT_ONE;
            if (err_evt && err_cnt != CNT_MAX)
                err_cnt <= err_cnt + CNT_ONE;
        end
    end

    for (genvar n = 0; n < 4; n++) begin : g_port
        pcileech_tlps128_reg_slice u_slice (
            .clk_pcie   (clk_pcie),
            .rst        (rst),
            .load       (load[n]),
            .in_beat    (in_beat),
            .space      (space[n]),
            .out_beat   (out_beat[n]),
            .out_tvalid (out_tvalid[n]),
            .out_tready (out_tready[n])
        );

        assign out_tdata[n*128 +: 128]     = out_beat[n].tdata;
        assign out_tkeepdw[n*4 +: 4]       = out_beat[n].tkeepdw;
        assign out_tuser[n*9 +: 9]         = out_beat[n].tuser;
        assign out_tlast[n]                = out_beat[n].tlast;
        assign pkt_cnt[n*CNT_W +: CNT_W]   = cnt[n];
    end

endmodule

// File: tb/tb_pcileech_tlps128_route_demux.sv
module tb_pcileech_tlps128_route_demux;

    logic         clk_pcie = 1'b0;
    always #5 clk_pcie = ~clk_pcie;

    // DUT A: default parameters, scoreboarded
    logic         rst;
    logic [127:0] in_tdata;
    logic [3:0]   in_tkeepdw;
    logic [8:0]   in_tuser;
    logic         in_tlast, in_tvalid, in_tready;
    logic [511:0] out_tdata;
    logic [15:0]  out_tkeepdw;
    logic [35:0]  out_tuser;
    logic [3:0]   out_tlast, out_tvalid, out_tready;
    logic [63:0]  pkt_cnt;
    logic [15:0]  err_cnt;

    // DUT B: port 2 dropped, 4-bit counters
    logic         b_rst;
    logic [127:0] b_in_tdata;
    logic [3:0]   b_in_tkeepdw;
    logic [8:0]   b_in_tuser;
    logic         b_in_tlast, b_in_tvalid, b_in_tready;
    logic [511:0] b_out_tdata;
    logic [15:0]  b_out_tkeepdw;
    logic [35:0]  b_out_tuser;
    logic [3:0]   b_out_tlast, b_out_tvalid, b_out_tready;
    logic [15:0]  b_pkt_cnt;
    logic [3:0]   b_err_cnt;

    pcileech_tlps128_route_demux u_dut (
        .clk_pcie(clk_pcie), .rst(rst),
        .in_tdata(in_tdata), .in_tkeepdw(in_tkeepdw), .in_tuser(in_tuser),
        .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tkeepdw(out_tkeepdw), .out_tuser(out_tuser),
        .out_tlast(out_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    pcileech_tlps128_route_demux #(.DROP_MASK(4'b0100), .CNT_W(4)) u_dut_b (
        .clk_pcie(clk_pcie), .rst(b_rst),
        .in_tdata(b_in_tdata), .in_tkeepdw(b_in_tkeepdw), .in_tuser(b_in_tuser),
        .in_tlast(b_in_tlast), .in_tvalid(b_in_tvalid), .in_tready(b_in_tready),
        .out_tdata(b_out_tdata), .out_tkeepdw(b_out_tkeepdw), .out_tuser(b_out_tuser),
        .out_tlast(b_out_tlast), .out_tvalid(b_out_tvalid), .out_tready(b_out_tready),
        .pkt_cnt(b_pkt_cnt), .err_cnt(b_err_cnt)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int acc_cycle = 0;
    int seq   = 0;
    logic b_v2_seen = 1'b0;

    logic [141:0] sbq [4][$];

    always @(posedge clk_pcie) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: pop and compare whenever a port hands over a beat.
    always @(negedge clk_pcie) begin
        for (int p = 0; p < 4; p++) begin
            if (out_tvalid[p] === 1'b1 && out_tready[p] === 1'b1) begin
                logic [141:0] got, e;
                got = {out_tdata[p*128 +: 128], out_tkeepdw[p*4 +: 4],
                       out_tuser[p*9 +: 9], out_tlast[p]};
                tests++;
                if (sbq[p].size() == 0) begin
                    fails++;
                    $display("FAIL port%0d_unexpected: got beat 0x%0h expected none", p, got);
                end else begin
                    e = sbq[p].pop_front();
                    if (got !== e) begin
                        fails++;
                        $display("FAIL port%0d_beat: got 0x%0h expected 0x%0h", p, got, e);
                    end
                end
            end
        end
        if (b_out_tvalid[2] === 1'b1)
            b_v2_seen <= 1'b1;
    end

    function automatic logic [127:0] mk(input logic [7:0] ft, input int s);
        return {32'(s), 32'hCAFE_0000 + 32'(s), 32'h1234_5678, ft, 24'h00_0001};
    endfunction

    // Drives one beat on DUT A; port<0 means no output is expected.
    task automatic send_a(input logic [7:0] ft, input logic fst, input logic lst, input int port);
        int n = 0;
        seq++;
        in_tdata   = mk(ft, seq);
        in_tkeepdw = 4'(seq);
        in_tuser   = {8'(seq), fst};
        in_tlast   = lst;
        in_tvalid  = 1'b1;
        @(negedge clk_pcie);
        while (in_tready !== 1'b1 && n < 200) begin
            @(negedge clk_pcie);
            n++;
        end
        if (in_tready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL a_accept_timeout: in_tready stuck at %b, required 1", in_tready);
            in_tvalid = 1'b0;
            return;
        end
        if (port >= 0)
            sbq[port].push_back({in_tdata, in_tkeepdw, in_tuser, in_tlast});
        acc_cycle = cyc;
        @(posedge clk_pcie); #1;
        in_tvalid = 1'b0;
        if (port >= 0)
            check("out_valid_latency", 64'(out_tvalid[port]), 64'd1);
    endtask

    task automatic send_b(input logic [7:0] ft, input logic fst, input logic lst, input logic chk_rdy);
        int n = 0;
        seq++;
        b_in_tdata   = mk(ft, seq);
        b_in_tkeepdw = 4'hF;
        b_in_tuser   = {8'(seq), fst};
        b_in_tlast   = lst;
        b_in_tvalid  = 1'b1;
        @(negedge clk_pcie);
        if (chk_rdy)
            check("b_drop_ready", 64'(b_in_tready), 64'd1);
        while (b_in_tready !== 1'b1 && n < 200) begin
            @(negedge clk_pcie);
            n++;
        end
        if (b_in_tready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL b_accept_timeout: in_tready stuck at %b, required 1", b_in_tready);
        end
        @(posedge clk_pcie); #1;
        b_in_tvalid = 1'b0;
    endtask

    task automatic check_cnts(input string name, input logic [15:0] c0, input logic [15:0] c1,
                              input logic [15:0] c2, input logic [15:0] c3, input logic [15:0] e);
        check({name, "_pkt_cnt"}, pkt_cnt, {c3, c2, c1, c0});
        check({name, "_err_cnt"}, 64'(err_cnt), 64'(e));
    endtask

    int t_start;

    initial begin
        rst = 1'b1; in_tvalid = 1'b0; in_tdata = '0; in_tkeepdw = '0; in_tuser = '0;
        in_tlast = 1'b0; out_tready = 4'hF;
        b_rst = 1'b1; b_in_tvalid = 1'b0; b_in_tdata = '0; b_in_tkeepdw = '0; b_in_tuser = '0;
        b_in_tlast = 1'b0; b_out_tready = 4'b1011;
        repeat (3) @(posedge clk_pcie);
        #1;
        check("rst_out_tvalid", 64'(out_tvalid), 64'd0);
        check("rst_in_tready", 64'(in_tready), 64'd0);
        check_cnts("rst", 0, 0, 0, 0, 0);
        check("b_rst_out_tvalid", 64'(b_out_tvalid), 64'd0);
        rst = 1'b0; b_rst = 1'b0;
        @(posedge clk_pcie); #1;

        // 1: back-to-back mixed stream, all sinks ready
        send_a(8'h4A, 1'b1, 1'b0, 0);
        t_start = acc_cycle;
        send_a(8'h4A, 1'b0, 1'b0, 0);
        send_a(8'h4A, 1'b0, 1'b1, 0);
        send_a(8'h00, 1'b1, 1'b1, 1);
        send_a(8'h44, 1'b1, 1'b0, 2);
        send_a(8'h44, 1'b0, 1'b1, 2);
        send_a(8'h30, 1'b1, 1'b1, 3);
        check("throughput_cycles", 64'(acc_cycle - t_start), 64'd6);
        repeat (2) @(posedge clk_pcie); #1;
        check_cnts("t1", 1, 1, 1, 1, 0);

        // 2: port 1 stalls during a 4-beat MWr, a Cpl follows
        out_tready = 4'b1101;
        fork
            begin
                send_a(8'h60, 1'b1, 1'b0, 1);
                send_a(8'h60, 1'b0, 1'b0, 1);
                send_a(8'h60, 1'b0, 1'b0, 1);
                send_a(8'h60, 1'b0, 1'b1, 1);
                send_a(8'h0A, 1'b1, 1'b1, 0);
            end
            begin
                repeat (3) @(posedge clk_pcie);
                @(negedge clk_pcie);
                check("stall_in_tready", 64'(in_tready), 64'd0);
                check("stall_cpl_cnt", pkt_cnt[15:0], 64'd1);
                repeat (7) @(posedge clk_pcie);
                #1 out_tready = 4'hF;
            end
        join
        repeat (3) @(posedge clk_pcie); #1;
        check_cnts("t2", 2, 2, 1, 1, 0);

        // 4: orphan beat, then a packet restarted by a new first beat
        send_a(8'h4A, 1'b0, 1'b1, -1);
        repeat (2) @(posedge clk_pcie); #1;
        check_cnts("orphan", 2, 2, 1, 1, 1);
        send_a(8'h40, 1'b1, 1'b0, 1);
        send_a(8'h40, 1'b0, 1'b0, 1);
        send_a(8'h4A, 1'b1, 1'b1, 0);
        repeat (2) @(posedge clk_pcie); #1;
        check_cnts("restart", 3, 2, 1, 1, 2);

        // 5: reset on beat 2 of a 3-beat CplD
        send_a(8'h4A, 1'b1, 1'b0, 0);
        seq++;
        in_tdata = mk(8'h4A, seq); in_tuser = 9'h0; in_tlast = 1'b0; in_tvalid = 1'b1;
        rst = 1'b1;
        @(posedge clk_pcie); #1;
        check("midrst_out_tvalid", 64'(out_tvalid), 64'd0);
        check_cnts("midrst", 0, 0, 0, 0, 0);
        in_tvalid = 1'b0;
        rst = 1'b0;
        @(posedge clk_pcie); #1;
        send_a(8'h04, 1'b1, 1'b1, 2);
        repeat (2) @(posedge clk_pcie); #1;
        check_cnts("postrst", 0, 0, 1, 0, 0);

        // 3: DROP_MASK=0100, port 2 never ready, 5 CfgRd packets
        send_b(8'h04, 1'b1, 1'b1, 1'b1);
        send_b(8'h04, 1'b1, 1'b0, 1'b1);
        send_b(8'h04, 1'b0, 1'b1, 1'b1);
        send_b(8'h04, 1'b1, 1'b1, 1'b1);
        send_b(8'h04, 1'b1, 1'b1, 1'b1);
        send_b(8'h04, 1'b1, 1'b1, 1'b1);
        repeat (2) @(posedge clk_pcie); #1;
        check("drop_valid_seen", 64'(b_v2_seen), 64'd0);
        check("drop_pkt_cnt2", 64'(b_pkt_cnt[11:8]), 64'd5);

        // 6: 4-bit counters, wrap and saturate
        b_out_tready = 4'hF;
        for (int i = 0; i < 17; i++)
            send_b(8'h0A, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            send_b(8'h0A, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_pcie); #1;
        check("wrap_pkt_cnt0", 64'(b_pkt_cnt[3:0]), 64'd1);
        check("sat_err_cnt", 64'(b_err_cnt), 64'd15);
        check("wrap_pkt_cnt2", 64'(b_pkt_cnt[11:8]), 64'd5);

        repeat (3) @(posedge clk_pcie); #1;
        for (int p = 0; p < 4; p++)
            check($sformatf("port%0d_drained", p), 64'(sbq[p].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
